completion_stream_sink: RTL and testbench

- Sits directly downstream of the completion data channel and consumes its write stream (data/valid/last/ready).
- Classifies each incoming burst. Single-beat completion report words are absorbed: NAND ready/busy is captured and a completion counter is bumped. All other bursts are forwarded to the host-side data stream.
- After each forwarded burst, emits one descriptor carrying the burst's beat count.

---
 rtl/completion_stream_sink.sv | 122 ++++++++++++
 tb/tb_completion_stream_sink.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/completion_stream_sink.sv
// Sink for the completion data channel: absorbs single-beat completion words
// (NAND ready/busy + counter) and forwards every other burst, then emits a length descriptor.
module completion_stream_sink #(
  parameter int          DataWidth           = 32,
  parameter int          InnerIFLengthWidth  = 16,
  parameter int          NumberOfWays        = 8,
  parameter logic [15:0] CompletionSignature = 16'hA501
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [DataWidth-1:0]          iSrcWriteData,
  input  logic                          iSrcWriteValid,
  input  logic                          iSrcWriteLast,
  output logic                          oSrcWriteReady,
  output logic [DataWidth-1:0]          oDstData,
  output logic                          oDstValid,
  output logic                          oDstLast,
  input  logic                          iDstReady,
  output logic [InnerIFLengthWidth-1:0] oDescLength,
  output logic                          oDescValid,
  input  logic                          iDescReady,
  output logic [NumberOfWays-1:0]       oReadyBusy,
  output logic                          oReadyBusyValid,
  output logic [15:0]                   oCompletionCount,
  output logic                          oOverflowError
);

  typedef enum logic [1:0] {S_Head, S_Body, S_Desc} state_t;

  state_t                        rState;
  state_t                        wNextState;
  logic [InnerIFLengthWidth-1:0] rBeatCount;
  logic                          wIsCmpl;
  logic                          wBeatAccept;
  logic                          wCountMax;
  logic [InnerIFLengthWidth-1:0] wCountNext;

  assign wIsCmpl     = iSrcWriteValid & iSrcWriteLast &
                       (iSrcWriteData[15:0] == CompletionSignature);
  assign wBeatAccept = iSrcWriteValid & iDstReady;
  assign wCountMax   = &rBeatCount;
  assign wCountNext  = wCountMax ? rBeatCount : rBeatCount + InnerIFLengthWidth'(1);

  // Data path is a pure pass-through; only the handshake is steered by state.
  assign oDstData = iSrcWriteData;
  assign oDstLast = iSrcWriteLast & oDstValid;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wNextState     = rState;
    oSrcWriteReady = 1'b0;
    oDstValid      = 1'b0;
    case (rState)
      S_Head: begin
        oSrcWriteReady = wIsCmpl ? 1'b1 : iDstReady;
        oDstValid      = iSrcWriteValid & ~wIsCmpl;
        if (wBeatAccept && !wIsCmpl)
          wNextState = iSrcWriteLast ? S_Desc : S_Body;
      end
      S_Body: begin
        oSrcWriteReady = iDstReady;
        oDstValid      = iSrcWriteValid;
        if (wBeatAccept && iSrcWriteLast)
          wNextState = S_Desc;
      end
      S_Desc: begin
        if (iDescReady)
          wNextState = S_Head;
      end
      default: wNextState = S_Head;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rState           <= S_Head;
      rBeatCount       <= '0;
      oDescLength      <= '0;
      oDescValid       <= 1'b0;
      oReadyBusy       <= '0;
      oReadyBusyValid  <= 1'b0;
      oCompletionCount <= '0;
      oOverflowError   <= 1'b0;
    end else begin
      rState          <= wNextState;
      oReadyBusyValid <= 1'b0;
      case (rState)
        S_Head: begin
          if (wIsCmpl) begin
            oReadyBusy       <= iSrcWriteData[16 +: NumberOfWays];
            oReadyBusyValid  <= 1'b1;
            oCompletionCount <= oCompletionCount + 16'd1;
          end else if (wBeatAccept) begin
            rBeatCount <= InnerIFLengthWidth'(1);
            if (iSrcWriteLast) begin
              oDescLength <= InnerIFLengthWidth'(1);
              oDescValid  <= 1'b1;
            end
          end
        end
        S_Body: begin
          if (wBeatAccept) begin
            rBeatCount <= wCountNext;
            if (wCountMax)
              oOverflowError <= 1'b1;
            if (iSrcWriteLast) begin
              oDescLength <= wCountNext;
              oDescValid  <= 1'b1;
            end
          end
        end
        S_Desc: begin
          if (iDescReady)
            oDescValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_completion_stream_sink.sv
// Self-checking bench: a burst-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations (one narrow-counter instance for saturation).
module tb_completion_stream_sink;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [31:0] iSrcWriteData;
  logic        iSrcWriteValid;
  logic        iSrcWriteLast;
  logic        iDstReady;
  logic        iDescReady;

  logic        oSrcWriteReady, oDstValid, oDstLast, oDescValid, oReadyBusyValid, oOverflowError;
  logic [31:0] oDstData;
  logic [15:0] oDescLength, oCompletionCount;
  logic [7:0]  oReadyBusy;

  logic        d2SrcWriteReady, d2DstValid, d2DstLast, d2DescValid, d2ReadyBusyValid, d2OverflowError;
  logic [31:0] d2DstData;
  logic [1:0]  d2DescLength;
  logic [15:0] d2CompletionCount;
  logic [7:0]  d2ReadyBusy;

  int nChecks = 0;
  int nErrors = 0;

  always #5 iClock = ~iClock;

  completion_stream_sink dut (
    .iClock(iClock), .iReset(iReset),
    .iSrcWriteData(iSrcWriteData), .iSrcWriteValid(iSrcWriteValid),
    .iSrcWriteLast(iSrcWriteLast), .oSrcWriteReady(oSrcWriteReady),
    .oDstData(oDstData), .oDstValid(oDstValid), .oDstLast(oDstLast), .iDstReady(iDstReady),
    .oDescLength(oDescLength), .oDescValid(oDescValid), .iDescReady(iDescReady),
    .oReadyBusy(oReadyBusy), .oReadyBusyValid(oReadyBusyValid),
    .oCompletionCount(oCompletionCount), .oOverflowError(oOverflowError)
  );

  completion_stream_sink #(.InnerIFLengthWidth(2)) dut2 (
    .iClock(iClock), .iReset(iReset),
    .iSrcWriteData(iSrcWriteData), .iSrcWriteValid(iSrcWriteValid),
    .iSrcWriteLast(iSrcWriteLast), .oSrcWriteReady(d2SrcWriteReady),
    .oDstData(d2DstData), .oDstValid(d2DstValid), .oDstLast(d2DstLast), .iDstReady(iDstReady),
    .oDescLength(d2DescLength), .oDescValid(d2DescValid), .iDescReady(iDescReady),
    .oReadyBusy(d2ReadyBusy), .oReadyBusyValid(d2ReadyBusyValid),
    .oCompletionCount(d2CompletionCount), .oOverflowError(d2OverflowError)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int beats, input int maxVal);
    return (beats > maxVal) ? maxVal : beats;
  endfunction

  // Reference model: burst-level bookkeeping with plain integers.
  bit          cmpOn = 0;
  bit          mInBurst = 0, mDescPending = 0, mRbPulse = 0, mOvf2 = 0;
  int          mBeats = 0, mDescBeats = 0;
  logic [7:0]  mRb = '0;
  logic [15:0] mCount = '0;
  logic [31:0] fwd[$];

  always @(negedge iClock) begin
    if (cmpOn) begin
      bit isCmpl, expReady, expValid, acc;
      isCmpl = iSrcWriteValid && iSrcWriteLast && (iSrcWriteData[15:0] == 16'hA501);
      if (mDescPending) begin
        expReady = 0; expValid = 0;
      end else if (mInBurst) begin
        expReady = iDstReady; expValid = iSrcWriteValid;
      end else begin
        expReady = isCmpl ? 1'b1 : iDstReady; expValid = iSrcWriteValid && !isCmpl;
      end
      check("ready",      64'(oSrcWriteReady),   64'(expReady));
      check("dst_valid",  64'(oDstValid),        64'(expValid));
      check("dst_data",   64'(oDstData),         64'(iSrcWriteData));
      check("dst_last",   64'(oDstLast),         64'(expValid && iSrcWriteLast));
      check("desc_valid", 64'(oDescValid),       64'(mDescPending));
      check("desc_len",   64'(oDescLength),      64'(sat(mDescBeats, 65535)));
      check("rb",         64'(oReadyBusy),       64'(mRb));
      check("rb_valid",   64'(oReadyBusyValid),  64'(mRbPulse));
      check("cmpl_count", 64'(oCompletionCount), 64'(mCount));
      check("overflow",   64'(oOverflowError),   64'(0));
      check("n_ready",    64'(d2SrcWriteReady),  64'(expReady));
      check("n_desc_len", 64'(d2DescLength),     64'(sat(mDescBeats, 3)));
      check("n_overflow", 64'(d2OverflowError),  64'(mOvf2));
      if (oDstValid && iDstReady) fwd.push_back(oDstData);

      acc = iSrcWriteValid && expReady;
      if (iReset) begin
        mInBurst = 0; mDescPending = 0; mRbPulse = 0; mOvf2 = 0;
        mBeats = 0; mDescBeats = 0; mRb = '0; mCount = '0;
      end else begin
        mRbPulse = 0;
        if (mDescPending) begin
          if (iDescReady) mDescPending = 0;
        end else if (acc) begin
          if (!mInBurst && isCmpl) begin
            mRb = iSrcWriteData[23:16]; mRbPulse = 1; mCount = mCount + 16'd1;
          end else begin
            mBeats = mInBurst ? mBeats + 1 : 1;
            if (mBeats > 3) mOvf2 = 1;
            if (iSrcWriteLast) begin
              mDescBeats = mBeats; mDescPending = 1; mInBurst = 0;
            end else begin
              mInBurst = 1;
            end
          end
        end
      end
    end
  end

  logic [31:0] burstData [0:15];

  task automatic tick();
    @(posedge iClock); #1;
  endtask

  task automatic cmplWord(input logic [31:0] d, input logic [7:0] expRb);
    iDstReady = 0; iSrcWriteData = d; iSrcWriteValid = 1; iSrcWriteLast = 1;
    @(negedge iClock);
    check("cmpl_accepted", 64'(oSrcWriteReady), 64'(1));
    check("cmpl_not_fwd",  64'(oDstValid),      64'(0));
    tick();
    iSrcWriteValid = 0; iSrcWriteLast = 0;
    @(negedge iClock);
    check("rb_lit",       64'(oReadyBusy),      64'(expRb));
    check("rb_pulse_lit", 64'(oReadyBusyValid), 64'(1));
    tick();
    @(negedge iClock);
    check("rb_pulse_end", 64'(oReadyBusyValid), 64'(0));
    tick();
  endtask

  task automatic sendBurst(input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit acc;
    fwd.delete();
    while (idx < n && cyc < 64) begin
      iSrcWriteData  = burstData[idx];
      iSrcWriteLast  = (idx == n - 1);
      iSrcWriteValid = 1;
      iDstReady      = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge iClock);
      acc = oSrcWriteReady;
      tick();
      if (acc) idx++;
      cyc++;
    end
    iSrcWriteValid = 0; iSrcWriteLast = 0; iDstReady = 1;
    check("burst_done", 64'(idx), 64'(n));
    check("fwd_count", 64'(fwd.size()), 64'(n));
    for (int i = 0; i < n && i < fwd.size(); i++)
      check("fwd_beat", 64'(fwd[i]), 64'(burstData[i]));
  endtask

  task automatic takeDesc(input int expLen, input int hold);
    bit found = 0;
    iDescReady = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge iClock);
      if (oDescValid) begin found = 1; break; end
    end
    check("desc_seen", 64'(found), 64'(1));
    check("desc_len_lit", 64'(oDescLength), 64'(expLen));
    for (int h = 0; h < hold; h++) begin
      check("desc_held",  64'(oDescValid),     64'(1));
      check("desc_block", 64'(oSrcWriteReady), 64'(0));
      @(negedge iClock);
    end
    @(posedge iClock); #1;
    iDescReady = 1;
    tick();
    iDescReady = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1; iSrcWriteData = '0; iSrcWriteValid = 0; iSrcWriteLast = 0;
    iDstReady = 0; iDescReady = 0;
    tick();
    cmpOn = 1;
    tick();
    iReset = 0;
    @(negedge iClock);
    check("reset_desc_valid", 64'(oDescValid),       64'(0));
    check("reset_count",      64'(oCompletionCount), 64'(0));
    tick();

    // Completion capture with downstream stalled.
    cmplWord(32'h005AA501, 8'h5A);
    check("count_one", 64'(oCompletionCount), 64'(1));

    // Plain 4-beat burst, descriptor held 3 cycles.
    for (int i = 0; i < 4; i++) burstData[i] = 32'h10 + 32'(i);
    sendBurst(4, 0);
    takeDesc(4, 3);

    // Backpressure on every other cycle.
    for (int i = 0; i < 3; i++) burstData[i] = 32'h30 + 32'(i);
    sendBurst(3, 1);
    takeDesc(3, 0);

    // Signature inside a burst is plain data.
    burstData[0] = 32'h20; burstData[1] = 32'h0000A501; burstData[2] = 32'h0000A501;
    sendBurst(3, 0);
    takeDesc(3, 1);
    check("count_unchanged", 64'(oCompletionCount), 64'(1));

    // Completion counter wrap.
    force dut.oCompletionCount = 16'hFFFF;
    #1 release dut.oCompletionCount;
    mCount = 16'hFFFF;
    cmplWord(32'h0081A501, 8'h81);
    check("count_wrap", 64'(oCompletionCount), 64'(0));

    // 5-beat burst saturates the 2-bit counter of the narrow instance.
    for (int i = 0; i < 5; i++) burstData[i] = 32'h50 + 32'(i);
    sendBurst(5, 0);
    takeDesc(5, 0);
    @(negedge iClock);
    check("sat_len",     64'(d2DescLength),    64'(3));
    check("sat_ovf",     64'(d2OverflowError), 64'(1));
    check("wide_no_ovf", 64'(oOverflowError),  64'(0));
    tick();

    // Reset after beat 2 of 4.
    iDstReady = 1; iSrcWriteValid = 1; iSrcWriteLast = 0;
    iSrcWriteData = 32'h40; tick();
    iSrcWriteData = 32'h41; tick();
    iSrcWriteValid = 0; iReset = 1;
    tick();
    iReset = 0;
    @(negedge iClock);
    check("rst_desc_len", 64'(oDescLength),      64'(0));
    check("rst_rb",       64'(oReadyBusy),       64'(0));
    check("rst_count",    64'(oCompletionCount), 64'(0));
    check("rst_ovf",      64'(d2OverflowError),  64'(0));
    tick();
    cmplWord(32'h00C3A501, 8'hC3);
    check("count_after_rst", 64'(oCompletionCount), 64'(1));

    repeat (2) tick();
    cmpOn = 0;
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
